// File: rtl/pipe_stage_regs_if.sv
// Bundle between fetch/hazard control (master) and the ID/EX/MEM/WB register bank (slave).
// PIPE_PERF_EN adds the stall_cnt/bubble_cnt performance counters.
interface pipe_stage_regs_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic [XLEN-1:0]  if_pc;
   logic [31:0]      if_instr;
   logic             if_valid;
   logic             pc_pause;
   logic [3:0]       pipe_pause;
   logic [3:0]       pipe_bubble;

   logic [XLEN-1:0]  id_pc;
   logic [31:0]      id_instr;
   logic             id_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [31:0]      ex_instr;
   logic             ex_valid;
   logic [XLEN-1:0]  mem_pc;
   logic [31:0]      mem_instr;
   logic             mem_valid;
   logic [XLEN-1:0]  wb_pc;
   logic [31:0]      wb_instr;
   logic             wb_valid;
   logic [CNT_W-1:0] retire_cnt;
   logic             proto_err;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;
`endif

   modport master (
      output if_pc, if_instr, if_valid, pc_pause, pipe_pause, pipe_bubble,
      input  id_pc, id_instr, id_valid, ex_pc, ex_instr, ex_valid,
      input  mem_pc, mem_instr, mem_valid, wb_pc, wb_instr, wb_valid,
`ifdef PIPE_PERF_EN
      input  stall_cnt, bubble_cnt,
`endif
      input  retire_cnt, proto_err
   );

   modport slave (
      input  if_pc, if_instr, if_valid, pc_pause, pipe_pause, pipe_bubble,
      output id_pc, id_instr, id_valid, ex_pc, ex_instr, ex_valid,
      output mem_pc, mem_instr, mem_valid, wb_pc, wb_instr, wb_valid,
`ifdef PIPE_PERF_EN
      output stall_cnt, bubble_cnt,
`endif
      output retire_cnt, proto_err
   );
endinterface

// File: rtl/pipe_stage_regs.sv
// ID/EX/MEM/WB pipeline registers driven by hazard-unit pause/bubble masks, with retire counter
// and sticky protocol-error flag. PIPE_PERF_EN adds stall and squash performance counters.
module pipe_stage_regs #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter int unsigned CNT_W     = 32
) (
   input logic             clk,
   input logic             rst_n,
   pipe_stage_regs_if.slave bus
);
   localparam int unsigned NumStages = 4;

   // Stage index 0..3 = ID, EX, MEM, WB (masks are ID-first from the MSB).
   logic [XLEN-1:0]  pc_q    [NumStages];
   logic [XLEN-1:0]  pc_d    [NumStages];
   logic [31:0]      instr_q [NumStages];
   logic [31:0]      instr_d [NumStages];
   logic [3:0]       valid_q;
   logic [3:0]       valid_d;
   logic [XLEN-1:0]  up_pc   [NumStages];
   logic [31:0]      up_instr[NumStages];
   logic [3:0]       up_valid;
   logic [3:0]       stage_pause;
   logic [3:0]       stage_bubble;
   logic [3:0]       up_held;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic             proto_err_q, proto_err_d;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [2:0]       squash_cnt;
`endif

   always_comb begin
      stage_pause  = {bus.pipe_pause[0], bus.pipe_pause[1], bus.pipe_pause[2], bus.pipe_pause[3]};
      stage_bubble = {bus.pipe_bubble[0], bus.pipe_bubble[1], bus.pipe_bubble[2],
                      bus.pipe_bubble[3]};
      up_held      = {stage_pause[2:0], bus.pc_pause};

      up_pc[0]    = bus.if_pc;
      up_instr[0] = bus.if_instr;
      up_valid[0] = bus.if_valid;
      for (int s = 1; s < NumStages; s++) begin
         up_pc[s]    = pc_q[s-1];
         up_instr[s] = instr_q[s-1];
         up_valid[s] = valid_q[s-1];
      end
`ifdef PIPE_PERF_EN
      squash_cnt = '0;
`endif
      for (int s = 0; s < NumStages; s++) begin
         pc_d[s]    = up_pc[s];
         instr_d[s] = up_instr[s];
         valid_d[s] = up_valid[s];
         // A held upstream must not be duplicated, so an unpaused stage behind it takes a bubble.
         if (stage_bubble[s] || (!stage_pause[s] && up_held[s])) begin
            pc_d[s]    = '0;
            instr_d[s] = NOP_INSTR;
            valid_d[s] = 1'b0;
`ifdef PIPE_PERF_EN
            if (valid_q[s]) squash_cnt = squash_cnt + 3'd1;
`endif
         end else if (stage_pause[s]) begin
            pc_d[s]    = pc_q[s];
            instr_d[s] = instr_q[s];
            valid_d[s] = valid_q[s];
         end
      end

      proto_err_d  = proto_err_q | (|(stage_pause & ~up_held));
      retire_cnt_d = retire_cnt_q + CNT_W'(valid_q[3] & ~stage_pause[3]);
`ifdef PIPE_PERF_EN
      stall_cnt_d  = stall_cnt_q + CNT_W'(bus.pc_pause);
      bubble_cnt_d = bubble_cnt_q + CNT_W'(squash_cnt);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NumStages; s++) begin
            pc_q[s]    <= '0;
            instr_q[s] <= NOP_INSTR;
         end
         valid_q      <= '0;
         retire_cnt_q <= '0;
         proto_err_q  <= 1'b0;
`ifdef PIPE_PERF_EN
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
`endif
      end else begin
         for (int s = 0; s < NumStages; s++) begin
            pc_q[s]    <= pc_d[s];
            instr_q[s] <= instr_d[s];
         end
         valid_q      <= valid_d;
         retire_cnt_q <= retire_cnt_d;
         proto_err_q  <= proto_err_d;
`ifdef PIPE_PERF_EN
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
`endif
      end
   end

   assign bus.id_pc      = pc_q[0];
   assign bus.id_instr   = instr_q[0];
   assign bus.id_valid   = valid_q[0];
   assign bus.ex_pc      = pc_q[1];
   assign bus.ex_instr   = instr_q[1];
   assign bus.ex_valid   = valid_q[1];
   assign bus.mem_pc     = pc_q[2];
   assign bus.mem_instr  = instr_q[2];
   assign bus.mem_valid  = valid_q[2];
   assign bus.wb_pc      = pc_q[3];
   assign bus.wb_instr   = instr_q[3];
   assign bus.wb_valid   = valid_q[3];
   assign bus.retire_cnt = retire_cnt_q;
   assign bus.proto_err  = proto_err_q;
`ifdef PIPE_PERF_EN
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;
`endif
endmodule
